img_write_ctrl: RTL and testbench
=================================

# img_write_ctrl

Streams one 640x480 RGB565 image from the pixel pipeline into consecutive SD-card sectors. Frame data is buffered in a 512-word FIFO, and one sector-write is issued to the SD write engine per 256 words. The block sits between the image source and the SD controller's write port, mirroring the sector-read sequencing on the read side. A trigger selects one of 16 image slots on the card.

## Interface
Parameters:
- PIC_BASE, 32'd16640: sector address of slot 0.
- SLOT_STRIDE, 32'd1280: sectors between consecutive slots.
- WR_NUM, 11'd1200: sectors per image (640*480*16/(256*16)).
- SEC_WORDS, 9'd256: 16-bit words per sector.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- wr_trig  in  1  one-cycle pulse to start capturing a frame.
- wr_slot  in  4  slot index, sampled with wr_trig.
- pix_valid  in  1  pixel word valid.
- pix_data  in  16  RGB565 pixel.
- pix_ready  out  1  block accepts pixel this cycle.
- wr_start_en  out  1  one-cycle pulse that starts a sector write.
- wr_sec_addr  out  32  sector address, stable from wr_start_en until the wr_busy falling edge.
- wr_req  in  1  SD engine requests the next data word.
- wr_data  out  16  data word to the SD engine.
- wr_busy  in  1  SD engine busy writing a sector.
- wr_done  out  1  one-cycle pulse after the last sector completes.
- wr_err  out  1  sticky underflow flag.
- wr_checksum  out  16  see Configuration.

## Operation
- State machine IDLE -> FILL -> START -> WAIT, then either back to FILL or to DONE -> IDLE.
- IDLE:
  - pix_ready=0.
  - On wr_trig: wr_sec_addr <= PIC_BASE + wr_slot*SLOT_STRIDE (32-bit unsigned, wraps mod 2^32).
  - Clear the sector counter, wr_err, and the checksum; go to FILL.
- FILL:
  - pix_ready = FIFO not full.
  - A pixel is pushed when pix_valid & pix_ready.
  - Go to START when FIFO count >= SEC_WORDS.
- START: pulse wr_start_en for one cycle; go to WAIT.
- WAIT:
  - Each wr_req pops one word. wr_data is registered and updated on the edge after wr_req is sampled high.
  - pix_ready stays active, so filling continues during the write.
  - wr_busy falling edge is detected through a two-flop delay (bat0, bat1), with neg = ~bat0 & bat1.
  - On the falling edge: sector counter +1 and wr_sec_addr +1.
  - If the counter was WR_NUM-1: go to DONE.
  - Otherwise: go to FILL.
- DONE: pulse wr_done; go to IDLE. Words remaining in the FIFO are flushed.
- Underflow: wr_req while the FIFO is empty sets wr_err (sticky), wr_data=16'd0, and the FIFO is not popped.
- Simultaneous push and pop: both happen and the count is unchanged.
- wr_trig outside IDLE is ignored.
- A wr_busy falling edge outside WAIT is ignored.

## Timing
- Reset values:
  - pix_ready=0, wr_start_en=0, wr_sec_addr=0, wr_data=0.
  - wr_done=0, wr_err=0, wr_checksum=0.
  - State IDLE, FIFO empty.
- Reset mid-operation: everything returns to these values immediately, with no sector completion. The SD engine is not aborted by this block.
- wr_trig to first pix_ready: 1 cycle.
- 256th push to wr_start_en: 2 cycles (FILL detects the count, then START).
- wr_busy falling edge (at the SD pin) to addr increment: 3 cycles (2 sync flops + registered update).
- Next wr_start_en:
  - Same cycle as FILL entry + 1 if the FIFO already holds >= 256 words.
  - Otherwise when the threshold is reached.
- wr_req to wr_data: 1 cycle.
- Back-to-back wr_req every cycle is supported.

## Configuration
- IMG_WR_CHECKSUM_EN defined: wr_checksum accumulates the 16-bit modular sum of every word popped to wr_data (underflow zeros excluded). It is cleared on wr_trig and held after DONE.
- Undefined: wr_checksum is tied to 16'd0 and the adder is removed.

## Test plan
- WR_NUM=2, wr_slot=3 -> wr_start_en twice, with wr_sec_addr 20480 then 20481. Words 0..511 arrive in order on wr_data; wr_done occurs once, 1 cycle after the second busy edge handling.
- Trigger without pixels, then pulse wr_req once -> no wr_start_en. If forced into WAIT via partial fill and a stalled source, wr_err=1 and wr_data=0.
- Pixel source pushes 512 words with no wr_req -> pix_ready drops after the 512th word. A pop of one word lets exactly one further push.
- Second wr_trig during WAIT with wr_slot=5 -> ignored, and wr_sec_addr continues from the slot-3 address.
- Reset asserted mid-WAIT of sector 1 -> all outputs at reset values the next cycle. A new wr_trig with slot 0 restarts at 16640.
- With IMG_WR_CHECKSUM_EN and data 1..512 over two sectors -> wr_checksum = 131328 mod 65536 = 0x0100. Without the macro, wr_checksum stays 0.

Source files
------------

// File: rtl/img_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// img_write_ctrl_if
//   Bundles the pixel-source, SD write-engine and status signals of
//   img_write_ctrl. The clock and reset stay plain module ports.
//
//   Signals:
//     wr_trig      one-cycle start pulse (source side)
//     wr_slot      image slot index, sampled with wr_trig
//     pix_valid    pixel word valid
//     pix_data     RGB565 pixel word
//     pix_ready    controller accepts a pixel this cycle
//     wr_start_en  one-cycle pulse that starts a sector write
//     wr_sec_addr  sector address of the current write
//     wr_req       SD engine requests the next data word
//     wr_data      data word to the SD engine
//     wr_busy      SD engine busy writing a sector
//     wr_done      one-cycle pulse after the last sector completes
//     wr_err       sticky underflow flag
//     wr_checksum  running 16-bit sum of the words handed to the engine
//
//   Modports:
//     slave  - the controller's view
//     master - the environment's view (pixel source + SD engine)
// ---------------------------------------------------------------------------
interface img_write_ctrl_if;
  logic        wr_trig;
  logic [3:0]  wr_slot;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_busy;
  logic        wr_done;
  logic        wr_err;
  logic [15:0] wr_checksum;

  modport slave (
    input  wr_trig, wr_slot, pix_valid, pix_data, wr_req, wr_busy,
    output pix_ready, wr_start_en, wr_sec_addr, wr_data, wr_done, wr_err,
           wr_checksum
  );

  modport master (
    output wr_trig, wr_slot, pix_valid, pix_data, wr_req, wr_busy,
    input  pix_ready, wr_start_en, wr_sec_addr, wr_data, wr_done, wr_err,
           wr_checksum
  );
endinterface

// File: rtl/img_write_ctrl.sv
// ---------------------------------------------------------------------------
// img_write_ctrl
//   Streams one RGB565 image from the pixel pipeline into consecutive SD-card
//   sectors. Pixels are buffered in a 512-word FIFO; every time 256 words are
//   available a sector write is started on the SD write engine and the engine
//   pulls the words out with wr_req. After WR_NUM sectors wr_done pulses and
//   the controller returns to idle.
//
//   Ports:
//     clk   in  system clock (single domain)
//     rst   in  asynchronous active-low reset
//     bus   img_write_ctrl_if.slave (pixel, SD-engine and status signals)
//
//   Parameters:
//     PIC_BASE     sector address of slot 0
//     SLOT_STRIDE  sectors between consecutive slots
//     WR_NUM       sectors per image
//     SEC_WORDS    16-bit words per sector
//
//   Build option:
//     IMG_WR_CHECKSUM_EN - when defined, wr_checksum accumulates the modular
//     sum of every word handed to the engine; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module img_write_ctrl #(
  parameter logic [31:0] PIC_BASE    = 32'd16640,
  parameter logic [31:0] SLOT_STRIDE = 32'd1280,
  parameter logic [10:0] WR_NUM      = 11'd1200,
  parameter logic [8:0]  SEC_WORDS   = 9'd256
) (
  input  logic            clk,
  input  logic            rst,
  img_write_ctrl_if.slave bus
);

  localparam logic [9:0] FIFO_FULL = 10'd512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_q;

  // FIFO storage and bookkeeping
  logic [15:0] mem_q [0:511];
  logic [8:0]  wr_ptr_q;
  logic [8:0]  rd_ptr_q;
  logic [9:0]  cnt_q;
  logic [9:0]  cnt_d;

  // wr_busy delay line used for falling-edge detection
  logic        bat0_q;
  logic        bat1_q;

  logic [10:0] sec_cnt_q;
  logic        pix_ready_q;
  logic        wr_start_en_q;
  logic        wr_done_q;
  logic        wr_err_q;
  logic [31:0] wr_sec_addr_q;
  logic [15:0] wr_data_q;

  logic        push_s;
  logic        pop_s;
  logic        under_s;
  logic        flush_s;
  logic        neg_s;
  logic        not_full_d_s;
  logic        last_sec_s;

  // Handshake decode and next FIFO occupancy
  always_comb begin
    push_s     = bus.pix_valid & pix_ready_q;
    // The engine is only served while a sector write is in flight.
    pop_s      = (state_q == ST_WAIT) & bus.wr_req & (cnt_q != 10'd0);
    under_s    = (state_q == ST_WAIT) & bus.wr_req & (cnt_q == 10'd0);
    flush_s    = (state_q == ST_DONE);
    neg_s      = ~bat0_q & bat1_q;
    last_sec_s = (sec_cnt_q == (WR_NUM - 11'd1));
    if (flush_s) begin
      cnt_d = 10'd0;
    end else if (push_s && !pop_s) begin
      cnt_d = cnt_q + 10'd1;
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - 10'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // pix_ready is registered from the next occupancy so it equals
    // "FIFO not full" in the cycle it is presented.
    not_full_d_s = (cnt_d != FIFO_FULL);
  end

  // FIFO pointers, occupancy and wr_busy delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 9'd0;
      rd_ptr_q <= 9'd0;
      cnt_q    <= 10'd0;
      bat0_q   <= 1'b0;
      bat1_q   <= 1'b0;
    end else begin
      bat0_q <= bus.wr_busy;
      bat1_q <= bat0_q;
      cnt_q  <= cnt_d;
      if (flush_s) begin
        wr_ptr_q <= 9'd0;
        rd_ptr_q <= 9'd0;
      end else begin
        if (push_s) begin
          wr_ptr_q <= wr_ptr_q + 9'd1;
        end
        if (pop_s) begin
          rd_ptr_q <= rd_ptr_q + 9'd1;
        end
      end
    end
  end

  // FIFO storage write port (no reset on the RAM array)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.pix_data;
    end
  end

  // Sector sequencing state machine with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sec_cnt_q     <= 11'd0;
      pix_ready_q   <= 1'b0;
      wr_start_en_q <= 1'b0;
      wr_done_q     <= 1'b0;
      wr_err_q      <= 1'b0;
      wr_sec_addr_q <= 32'd0;
      wr_data_q     <= 16'd0;
    end else begin
      wr_start_en_q <= 1'b0;
      wr_done_q     <= 1'b0;

      // Data path to the engine; an underflow returns zero without popping.
      if (pop_s) begin
        wr_data_q <= mem_q[rd_ptr_q];
      end else if (under_s) begin
        wr_data_q <= 16'd0;
      end
      if (under_s) begin
        wr_err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.wr_trig) begin
            state_q       <= ST_FILL;
            wr_sec_addr_q <= PIC_BASE + (32'(bus.wr_slot) * SLOT_STRIDE);
            sec_cnt_q     <= 11'd0;
            wr_err_q      <= 1'b0;
            pix_ready_q   <= 1'b1;
          end else begin
            pix_ready_q   <= 1'b0;
          end
        end
        ST_FILL: begin
          pix_ready_q <= not_full_d_s;
          if (cnt_q >= {1'b0, SEC_WORDS}) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          // The start pulse is presented in the first WAIT cycle.
          wr_start_en_q <= 1'b1;
          pix_ready_q   <= not_full_d_s;
          state_q       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (neg_s) begin
            sec_cnt_q     <= sec_cnt_q + 11'd1;
            wr_sec_addr_q <= wr_sec_addr_q + 32'd1;
            if (last_sec_s) begin
              state_q     <= ST_DONE;
              pix_ready_q <= 1'b0;
            end else begin
              state_q     <= ST_FILL;
              pix_ready_q <= not_full_d_s;
            end
          end else begin
            pix_ready_q <= not_full_d_s;
          end
        end
        ST_DONE: begin
          // FIFO is flushed this cycle; wr_done is seen the next one.
          wr_done_q   <= 1'b1;
          pix_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          pix_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMG_WR_CHECKSUM_EN
  logic [15:0] checksum_q;
  logic        trig_s;

  assign trig_s = (state_q == ST_IDLE) & bus.wr_trig;

  // Modular sum of every word actually popped to the engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= 16'd0;
    end else if (trig_s) begin
      checksum_q <= 16'd0;
    end else if (pop_s) begin
      checksum_q <= checksum_q + mem_q[rd_ptr_q];
    end
  end

  assign bus.wr_checksum = checksum_q;
`else
  assign bus.wr_checksum = 16'd0;
`endif

  assign bus.pix_ready   = pix_ready_q;
  assign bus.wr_start_en = wr_start_en_q;
  assign bus.wr_sec_addr = wr_sec_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.wr_err      = wr_err_q;

endmodule

// File: tb/tb_img_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_img_write_ctrl
//   Self-checking bench for img_write_ctrl (WR_NUM overridden to 2).
//   A randomized pixel source and a behavioural SD write engine run in one
//   per-cycle step task; a word queue, the slot address rule and a running
//   sum provide the expected values.
// ---------------------------------------------------------------------------
module tb_img_write_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  img_write_ctrl_if ifc ();

  img_write_ctrl #(.WR_NUM(11'd2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;

  logic [15:0] q_exp[$];
  int          src_left = 0;
  logic [15:0] src_val = 16'd0;
  bit          src_always = 1'b0;
  int          pushes = 0;

  bit          eng_en = 1'b0;
  int          eng_left = 0;
  bit          eng_extra = 1'b0;
  bit          req_pend = 1'b0;
  bit          req_under = 1'b0;

  bit          trig_pend = 1'b0;
  logic [3:0]  trig_slot = 4'd0;

  logic [31:0] exp_addr = 32'd0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] ck_model = 16'd0;
  int          stepn = 0;
  int          push256_step = 0;
  int          start_step = 0;
  int          start_before = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_ck();
`ifdef IMG_WR_CHECKSUM_EN
    return ck_model;
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_reset(input string pfx);
    chk({pfx, "_pix_ready"},   32'(ifc.pix_ready),   32'd0);
    chk({pfx, "_start_en"},    32'(ifc.wr_start_en), 32'd0);
    chk({pfx, "_sec_addr"},    ifc.wr_sec_addr,      32'd0);
    chk({pfx, "_wr_data"},     32'(ifc.wr_data),     32'd0);
    chk({pfx, "_wr_done"},     32'(ifc.wr_done),     32'd0);
    chk({pfx, "_wr_err"},      32'(ifc.wr_err),      32'd0);
    chk({pfx, "_checksum"},    32'(ifc.wr_checksum), 32'd0);
  endtask

  // One clock: sample at the falling edge, then drive the next inputs.
  task automatic step();
    logic [15:0] w;
    @(negedge clk);
    stepn++;
    if (ifc.wr_done) done_cnt++;

    // Result of the request issued on the previous step
    if (req_pend) begin
      if (req_under) begin
        chk("underflow_data", 32'(ifc.wr_data), 32'd0);
        chk("underflow_err",  32'(ifc.wr_err),  32'd1);
      end else begin
        if (q_exp.size() != 0) w = q_exp.pop_front();
        else w = 16'hxxxx;
        chk("wr_data", 32'(ifc.wr_data), 32'(w));
        ck_model = ck_model + w;
      end
    end
    req_pend   = 1'b0;
    req_under  = 1'b0;
    ifc.wr_req = 1'b0;

    ifc.wr_trig = trig_pend;
    ifc.wr_slot = trig_slot;
    trig_pend   = 1'b0;

    // SD write engine
    if (eng_en && ifc.wr_start_en) begin
      start_cnt++;
      start_step = stepn;
      chk("start_addr", ifc.wr_sec_addr, exp_addr);
      ifc.wr_busy = 1'b1;
      eng_left    = 256;
    end else if (ifc.wr_busy) begin
      chk("addr_stable", ifc.wr_sec_addr, exp_addr);
      if (eng_left > 0) begin
        if ($urandom_range(0, 3) != 0) begin
          ifc.wr_req = 1'b1;
          req_pend   = 1'b1;
          eng_left--;
        end
      end else if (eng_extra) begin
        ifc.wr_req = 1'b1;
        req_pend   = 1'b1;
        req_under  = 1'b1;
        eng_extra  = 1'b0;
      end else begin
        ifc.wr_busy = 1'b0;
        exp_addr    = exp_addr + 32'd1;
      end
    end

    // Pixel source
    ifc.pix_valid = 1'b0;
    if (src_left > 0 && (src_always || $urandom_range(0, 1) == 1)) begin
      ifc.pix_valid = 1'b1;
      ifc.pix_data  = src_val;
      if (ifc.pix_ready) begin
        q_exp.push_back(src_val);
        src_val = src_val + 16'd1;
        src_left--;
        pushes++;
        if (pushes == 256) push256_step = stepn;
      end
    end
  endtask

  initial begin
    ifc.wr_trig   = 1'b0;
    ifc.wr_slot   = 4'd0;
    ifc.pix_valid = 1'b0;
    ifc.pix_data  = 16'd0;
    ifc.wr_req    = 1'b0;
    ifc.wr_busy   = 1'b0;

    // ---- power-on reset ----
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b1;

    // ---- two-sector image into slot 3, trigger during WAIT ignored ----
    exp_addr = 32'd20480;
    ck_model = 16'd0;
    trig_pend = 1'b1;
    trig_slot = 4'd3;
    src_left = 512; src_val = 16'd0; src_always = 1'b0; pushes = 0;
    eng_en = 1'b1;
    step();
    step();
    chk("trig_to_ready", 32'(ifc.pix_ready), 32'd1);
    for (int i = 0; i < 3000 && start_cnt < 1; i++) step();
    chk("s1_first_start", 32'(start_cnt), 32'd1);
    repeat (20) step();
    trig_pend = 1'b1;
    trig_slot = 4'd5;
    for (int i = 0; i < 5000 && done_cnt < 1; i++) step();
    chk("s1_done", 32'(done_cnt), 32'd1);
    repeat (5) step();
    chk("s1_done_once",  32'(done_cnt),  32'd1);
    chk("s1_starts",     32'(start_cnt), 32'd2);
    chk("s1_pushes",     32'(pushes),    32'd512);
    chk("s1_queue_left", 32'(q_exp.size()), 32'd0);
    chk("s1_final_addr", ifc.wr_sec_addr, 32'd20482);
    chk("s1_err",        32'(ifc.wr_err), 32'd0);
    chk("s1_checksum",   32'(ifc.wr_checksum), 32'(exp_ck()));
    chk("s1_idle_ready", 32'(ifc.pix_ready), 32'd0);

    // ---- slot 1: no pixels, then one sector with an extra request ----
    start_before = start_cnt;
    exp_addr = 32'd17920;
    ck_model = 16'd0;
    trig_pend = 1'b1;
    trig_slot = 4'd1;
    step();
    step();
    ifc.wr_req = 1'b1;
    repeat (20) step();
    chk("s2_no_start", 32'(start_cnt), 32'(start_before));
    chk("s2_fill_err", 32'(ifc.wr_err), 32'd0);
    src_left = 256; src_val = 16'd1000; src_always = 1'b1; pushes = 0;
    eng_extra = 1'b1;
    for (int i = 0; i < 1000 && start_cnt < start_before + 1; i++) step();
    chk("s2_start", 32'(start_cnt), 32'(start_before + 1));
    chk("s2_push_to_start", 32'(start_step - push256_step), 32'd3);
    for (int i = 0; i < 2000 && ifc.wr_busy; i++) step();
    chk("s2_busy_released", 32'(ifc.wr_busy), 32'd0);
    repeat (4) step();
    chk("s2_err_sticky", 32'(ifc.wr_err), 32'd1);
    chk("s2_addr_next",  ifc.wr_sec_addr, 32'd17921);
    chk("s2_checksum",   32'(ifc.wr_checksum), 32'(exp_ck()));

    // ---- second sector, reset while it is being written ----
    src_left = 256; src_val = 16'd3000; src_always = 1'b0;
    for (int i = 0; i < 2000 && start_cnt < start_before + 2; i++) step();
    chk("s3_start", 32'(start_cnt), 32'(start_before + 2));
    repeat (60) step();
    rst = 1'b0;
    ifc.wr_busy = 1'b0; ifc.wr_req = 1'b0; ifc.pix_valid = 1'b0;
    req_pend = 1'b0; eng_left = 0; src_left = 0;
    q_exp.delete();
    ck_model = 16'd0;
    step();
    check_reset("midwait");
    rst = 1'b1;

    // ---- slot 0: fill the FIFO with no engine activity ----
    exp_addr = 32'd16640;
    trig_pend = 1'b1;
    trig_slot = 4'd0;
    eng_en = 1'b0;
    src_left = 600; src_val = 16'd1; src_always = 1'b1; pushes = 0;
    step();
    for (int i = 0; i < 800 && pushes < 512; i++) step();
    repeat (5) step();
    chk("s4_pushes_full", 32'(pushes), 32'd512);
    chk("s4_ready_full",  32'(ifc.pix_ready), 32'd0);
    chk("s4_addr",        ifc.wr_sec_addr, 32'd16640);
    ifc.wr_req = 1'b1;
    req_pend = 1'b1;
    repeat (6) step();
    chk("s4_one_more_push", 32'(pushes), 32'd513);
    chk("s4_ready_again",   32'(ifc.pix_ready), 32'd0);
    chk("s4_checksum",      32'(ifc.wr_checksum), 32'(exp_ck()));

    rst = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
